fft_host_driver: RTL

// - Host-side transmitter for the FFT butterfly's switch/ReadyIn operand protocol: drives sw and ReadyIn, reads LED.
// - Latches one butterfly frame (a, b, w; Re/Im each) on start and steps the FFT through its sequence:
//   6 operand loads, 1 compute step, 4 display steps.
// - Captures the four LED result words (Rez, Imz, Rey, Imy) into registers and flags completion.
// - Sits between a test/control host and the FFT top; replaces manual switch and button operation.

---
 rtl/fft_if_pkg.sv | 30 +++
 rtl/fft_step_timer.sv | 23 ++
 rtl/fft_host_driver.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fft_if_pkg.sv
// Shared types for the FFT host driver and the FFT control bench.
package fft_if_pkg;

   // Driver phase within one step: operand setup, strobe, post-strobe gap.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_GAP,
      ST_DONE
   } drv_state_t;

   // Step names in the order the FFT control expects them.
   typedef enum logic [3:0] {
      LD_REA, LD_IMA, LD_REB, LD_IMB, LD_REW, LD_IMW,
      COMPUTE,
      DSP_REZ, DSP_IMZ, DSP_REY, DSP_IMY
   } step_t;

   localparam logic [3:0] NUM_STEPS  = 4'd11;
   localparam logic [3:0] FIRST_DISP = 4'd7;

   // Longest phase sets the timer width.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/fft_step_timer.sv
// Loadable down-counter; zero_o marks the last cycle of the current phase.
module fft_step_timer #(
   parameter int W = 3
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   // Reload on phase entry, otherwise count down and park at zero.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                cnt_q <= '0;
      else if (load_i)          cnt_q <= load_val_i;
      else if (cnt_q != '0)     cnt_q <= cnt_q - 1'b1;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fft_host_driver.sv
// Host-side sequencer: feeds one butterfly frame to the FFT over sw/ReadyIn
// and captures the four displayed result words from LED.
module fft_host_driver
   import fft_if_pkg::*;
#(
   parameter int n       = 8,
   parameter int SETUP   = 2,
   parameter int PULSE_W = 4,
   parameter int GAP     = 4
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         start,
   input  logic [n-1:0] a_re,
   input  logic [n-1:0] a_im,
   input  logic [n-1:0] b_re,
   input  logic [n-1:0] b_im,
   input  logic [n-1:0] w_re,
   input  logic [n-1:0] w_im,
   output logic [n-1:0] sw,
   output logic         ReadyIn,
   input  logic [n-1:0] LED,
   output logic [n-1:0] z_re,
   output logic [n-1:0] z_im,
   output logic [n-1:0] y_re,
   output logic [n-1:0] y_im,
   output logic         busy,
   output logic         done
);

   localparam int TW = $clog2(max3(SETUP, PULSE_W, GAP) + 1);
   localparam logic [TW-1:0] LD_SETUP = TW'(SETUP - 1);
   localparam logic [TW-1:0] LD_PULSE = TW'(PULSE_W - 1);
   localparam logic [TW-1:0] LD_GAP   = TW'(GAP - 1);

   drv_state_t            state_q, state_d;
   logic [3:0]            step_q, step_d;
   logic [5:0][n-1:0]     ops_q, ops_d;
   logic [3:0][n-1:0]     res_q, res_d;
   logic [n-1:0]          sw_q, sw_d;
   logic                  rdy_q, rdy_d;
   logic                  tmr_load;
   logic [TW-1:0]         tmr_val;
   logic                  tmr_zero;
   logic [1:0]            disp_idx;

   fft_step_timer #(.W(TW)) u_tmr (
      .Clock      (Clock),
      .Reset      (Reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   assign disp_idx = 2'(step_q - FIRST_DISP);

   // State, step, operand latch, results and the registered bus outputs.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         ops_q   <= '0;
         res_q   <= '0;
         sw_q    <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         ops_q   <= ops_d;
         res_q   <= res_d;
         sw_q    <= sw_d;
         rdy_q   <= rdy_d;
      end
   end

   // Phase sequencing; sw/ReadyIn are decoded from the next state so the
   // pins themselves come straight from flops.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      ops_d    = ops_q;
      res_d    = res_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               ops_d    = {w_im, w_re, b_im, b_re, a_im, a_re};
               step_d   = '0;
               state_d  = ST_SETUP;
               tmr_load = 1'b1;
               tmr_val  = LD_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = LD_PULSE;
            end
         end
         ST_PULSE: begin
            if (tmr_zero) begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
               tmr_val  = LD_GAP;
            end
         end
         ST_GAP: begin
            if (tmr_zero) begin
               if (step_q >= FIRST_DISP) res_d[disp_idx] = LED;
               if (step_q == NUM_STEPS - 4'd1) begin
                  state_d = ST_DONE;
               end else begin
                  step_d   = step_q + 4'd1;
                  state_d  = ST_SETUP;
                  tmr_load = 1'b1;
                  tmr_val  = LD_SETUP;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      sw_d = '0;
      if ((state_d == ST_SETUP || state_d == ST_PULSE || state_d == ST_GAP) &&
          step_d <= 4'(LD_IMW))
         sw_d = ops_d[step_d[2:0]];
      rdy_d = (state_d == ST_PULSE);
   end

   assign sw      = sw_q;
   assign ReadyIn = rdy_q;
   assign z_re    = res_q[0];
   assign z_im    = res_q[1];
   assign y_re    = res_q[2];
   assign y_im    = res_q[3];
   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);

endmodule
